// File: rtl/mem2axi.sv
// rtl/mem2axi.sv - core data-port (req/gnt/rvalid) to single-beat AXI4 master bridge
// One transaction in flight; AW and W complete independently before the B response is taken.
module mem2axi #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int BE_WIDTH   = 4,
   parameter int ID_WIDTH   = 8,
   parameter int USER_WIDTH = 8,
   parameter int AXI_ID     = 0
) (
   input  logic                  clk_i,
   input  logic                  reset_ni,
   input  logic                  data_req_i,
   input  logic                  data_we_i,
   input  logic [ADDR_WIDTH-1:0] data_addr_i,
   input  logic [BE_WIDTH-1:0]   data_be_i,
   input  logic [DATA_WIDTH-1:0] data_wdata_i,
   output logic                  data_gnt_o,
   output logic                  data_rvalid_o,
   output logic [DATA_WIDTH-1:0] data_rdata_o,
   output logic                  data_err_o,
   output logic [ID_WIDTH-1:0]   m_axi_awid,
   output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic [7:0]            m_axi_awlen,
   output logic [2:0]            m_axi_awsize,
   output logic [1:0]            m_axi_awburst,
   output logic                  m_axi_awlock,
   output logic [3:0]            m_axi_awcache,
   output logic [2:0]            m_axi_awprot,
   output logic [3:0]            m_axi_awqos,
   output logic [3:0]            m_axi_awregion,
   output logic [USER_WIDTH-1:0] m_axi_awuser,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [DATA_WIDTH-1:0] m_axi_wdata,
   output logic [BE_WIDTH-1:0]   m_axi_wstrb,
   output logic                  m_axi_wlast,
   output logic [USER_WIDTH-1:0] m_axi_wuser,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   input  logic [ID_WIDTH-1:0]   m_axi_bid,
   input  logic [1:0]            m_axi_bresp,
   input  logic [USER_WIDTH-1:0] m_axi_buser,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,
   output logic [ID_WIDTH-1:0]   m_axi_arid,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic                  m_axi_arlock,
   output logic [3:0]            m_axi_arcache,
   output logic [2:0]            m_axi_arprot,
   output logic [3:0]            m_axi_arqos,
   output logic [3:0]            m_axi_arregion,
   output logic [USER_WIDTH-1:0] m_axi_aruser,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [ID_WIDTH-1:0]   m_axi_rid,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rlast,
   input  logic [USER_WIDTH-1:0] m_axi_ruser,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready
);

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, DONE} state_e;

   state_e                  state_q, state_d;
   logic                    aw_pend_q, aw_pend_d;
   logic                    w_pend_q, w_pend_d;
   logic                    ar_pend_q, ar_pend_d;
   logic [1:0]              resp_q, resp_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [ADDR_WIDTH-3:0]   addr_q;
   logic [BE_WIDTH-1:0]     be_q;
   logic [DATA_WIDTH-1:0]   wdata_q;

   assign data_gnt_o = data_req_i & (state_q == IDLE) & reset_ni;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q   <= IDLE;
         aw_pend_q <= 1'b0;
         w_pend_q  <= 1'b0;
         ar_pend_q <= 1'b0;
         resp_q    <= 2'b00;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         aw_pend_q <= aw_pend_d;
         w_pend_q  <= w_pend_d;
         ar_pend_q <= ar_pend_d;
         resp_q    <= resp_d;
         rdata_q   <= rdata_d;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
      end else if (data_gnt_o) begin
         addr_q  <= data_addr_i[ADDR_WIDTH-1:2];
         be_q    <= data_be_i;
         wdata_q <= data_wdata_i;
      end
   end

   // The pending flags double as the AW/W/AR valids, so they already hold until their own handshake.
   always_comb begin
      state_d   = state_q;
      aw_pend_d = aw_pend_q;
      w_pend_d  = w_pend_q;
      ar_pend_d = ar_pend_q;
      resp_d    = resp_q;
      rdata_d   = rdata_q;
      case (state_q)
         IDLE: begin
            if (data_gnt_o) begin
               if (data_we_i) begin
                  state_d   = WR_REQ;
                  aw_pend_d = 1'b1;
                  w_pend_d  = 1'b1;
               end else begin
                  state_d   = RD_REQ;
                  ar_pend_d = 1'b1;
               end
            end
         end
         WR_REQ: begin
            if (m_axi_awready) aw_pend_d = 1'b0;
            if (m_axi_wready)  w_pend_d  = 1'b0;
            if (!aw_pend_d && !w_pend_d) state_d = WR_RSP;
         end
         WR_RSP: begin
            if (m_axi_bvalid) begin
               resp_d  = m_axi_bresp;
               state_d = DONE;
            end
         end
         RD_REQ: begin
            if (m_axi_arready) begin
               ar_pend_d = 1'b0;
               state_d   = RD_RSP;
            end
         end
         RD_RSP: begin
            if (m_axi_rvalid) begin
               resp_d  = m_axi_rresp;
               rdata_d = m_axi_rdata;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign data_rvalid_o = (state_q == DONE);
   assign data_err_o    = (state_q == DONE) & (resp_q != 2'b00);
   assign data_rdata_o  = rdata_q;

   assign m_axi_awid     = ID_WIDTH'(AXI_ID);
   assign m_axi_awaddr   = {addr_q, 2'b00};
   assign m_axi_awlen    = 8'd0;
   assign m_axi_awsize   = 3'b010;
   assign m_axi_awburst  = 2'b01;
   assign m_axi_awlock   = 1'b0;
   assign m_axi_awcache  = 4'b0000;
   assign m_axi_awprot   = 3'b000;
   assign m_axi_awqos    = 4'd0;
   assign m_axi_awregion = 4'd0;
   assign m_axi_awuser   = '0;
   assign m_axi_awvalid  = aw_pend_q;

   assign m_axi_wdata    = wdata_q;
   assign m_axi_wstrb    = be_q;
   assign m_axi_wlast    = 1'b1;
   assign m_axi_wuser    = '0;
   assign m_axi_wvalid   = w_pend_q;

   assign m_axi_bready   = (state_q == WR_RSP);

   assign m_axi_arid     = ID_WIDTH'(AXI_ID);
   assign m_axi_araddr   = {addr_q, 2'b00};
   assign m_axi_arlen    = 8'd0;
   assign m_axi_arsize   = 3'b010;
   assign m_axi_arburst  = 2'b01;
   assign m_axi_arlock   = 1'b0;
   assign m_axi_arcache  = 4'b0000;
   assign m_axi_arprot   = 3'b000;
   assign m_axi_arqos    = 4'd0;
   assign m_axi_arregion = 4'd0;
   assign m_axi_aruser   = '0;
   assign m_axi_arvalid  = ar_pend_q;

   assign m_axi_rready   = (state_q == RD_RSP);

   // Single-beat, single-ID traffic: response IDs, user bits and rlast carry no information here.
   logic unused_inputs;
   assign unused_inputs = ^{m_axi_bid, m_axi_buser, m_axi_rid, m_axi_ruser, m_axi_rlast,
                            data_addr_i[1:0]};

endmodule

// File: tb/tb_mem2axi.sv
// tb/tb_mem2axi.sv - scoreboard bench for mem2axi with a delay-programmable AXI slave model
module tb_mem2axi;

   logic        clk_i = 1'b0;
   logic        reset_ni = 1'b0;
   logic        data_req_i = 1'b0, data_we_i = 1'b0;
   logic [31:0] data_addr_i = '0, data_wdata_i = '0;
   logic [3:0]  data_be_i = '0;
   logic        data_gnt_o, data_rvalid_o, data_err_o;
   logic [31:0] data_rdata_o;
   logic [7:0]  m_axi_awid, m_axi_awlen, m_axi_arid, m_axi_arlen;
   logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
   logic [2:0]  m_axi_awsize, m_axi_awprot, m_axi_arsize, m_axi_arprot;
   logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
   logic        m_axi_awlock, m_axi_arlock;
   logic [3:0]  m_axi_awcache, m_axi_awqos, m_axi_awregion, m_axi_wstrb;
   logic [3:0]  m_axi_arcache, m_axi_arqos, m_axi_arregion;
   logic [7:0]  m_axi_awuser, m_axi_wuser, m_axi_aruser;
   logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_wlast;
   logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
   logic        m_axi_rvalid, m_axi_rready;
   logic [7:0]  m_axi_bid = 8'h0, m_axi_buser = 8'h0, m_axi_rid = 8'h0, m_axi_ruser = 8'h0;
   logic        m_axi_rlast = 1'b1;

   mem2axi dut (
      .clk_i(clk_i), .reset_ni(reset_ni),
      .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
      .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
      .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
      .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
      .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
      .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
      .m_axi_awregion(m_axi_awregion), .m_axi_awuser(m_axi_awuser),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_wuser(m_axi_wuser), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_buser(m_axi_buser),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
      .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
      .m_axi_arregion(m_axi_arregion), .m_axi_aruser(m_axi_aruser),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rlast(m_axi_rlast), .m_axi_ruser(m_axi_ruser), .m_axi_rvalid(m_axi_rvalid),
      .m_axi_rready(m_axi_rready)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc = cyc + 1;

   typedef struct { logic [31:0] rdata; logic err; } rsp_t;
   rsp_t        rsp_q[$];
   logic [31:0] aw_q[$];
   logic [35:0] w_q[$];
   logic [31:0] ar_q[$];
   logic [1:0]  slv_b_q[$];
   logic [33:0] slv_r_q[$];
   logic [31:0] model_rdata = '0;

   int n_cmp = 0, n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Slave model: readies decided mid-cycle; B/R responses may be offered before the bridge wants them.
   int   aw_wait = 0, w_wait = 0, ar_wait = 0;
   int   aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
   logic aw_done = 0, w_done = 0, ar_done = 0, b_hs = 0, r_hs = 0;
   initial begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
      m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rdata = 0;
      forever begin
         @(negedge clk_i);
         if (!reset_ni) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
            m_axi_bvalid = 0; m_axi_rvalid = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
            aw_done = 0; w_done = 0; ar_done = 0; b_hs = 0; r_hs = 0;
         end else begin
            if (b_hs) begin m_axi_bvalid = 0; b_hs = 0; end
            if (r_hs) begin m_axi_rvalid = 0; r_hs = 0; end
            if (m_axi_awvalid) begin
               m_axi_awready = (aw_cnt == aw_wait);
               if (m_axi_awready) aw_done = 1;
               aw_cnt++;
            end else begin m_axi_awready = 0; aw_cnt = 0; end
            if (m_axi_wvalid) begin
               m_axi_wready = (w_cnt == w_wait);
               if (m_axi_wready) w_done = 1;
               w_cnt++;
            end else begin m_axi_wready = 0; w_cnt = 0; end
            if (m_axi_arvalid) begin
               m_axi_arready = (ar_cnt == ar_wait);
               if (m_axi_arready) ar_done = 1;
               ar_cnt++;
            end else begin m_axi_arready = 0; ar_cnt = 0; end
            if (aw_done && w_done && !m_axi_bvalid && slv_b_q.size() > 0) begin
               m_axi_bresp = slv_b_q.pop_front();
               m_axi_bvalid = 1; aw_done = 0; w_done = 0;
            end
            if (ar_done && !m_axi_rvalid && slv_r_q.size() > 0) begin
               {m_axi_rdata, m_axi_rresp} = slv_r_q.pop_front();
               m_axi_rvalid = 1; ar_done = 0;
            end
            if (m_axi_bvalid && m_axi_bready) b_hs = 1;
            if (m_axi_rvalid && m_axi_rready) r_hs = 1;
         end
      end
   end

   // Monitor: checks AXI payloads against expectations and pops the response scoreboard.
   int   rv_count = 0, rv_cyc = 0, aw_hs_cyc = 0, w_hs_cyc = 0, ar_hs_cyc = 0;
   int   bready_cyc = 0, ar_vcnt = 0, ar_cycles_last = 0;
   logic bready_prev = 0;
   initial begin
      forever begin
         @(negedge clk_i); #2;
         if (!reset_ni) begin
            ar_vcnt = 0; bready_prev = 0;
         end else begin
            if (m_axi_awvalid) begin
               if (aw_q.size() == 0) check("aw_unexpected", 1, 0);
               else check("awaddr", m_axi_awaddr, aw_q[0]);
               if (m_axi_awready) begin
                  check("aw_fixed", {m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awid},
                        {8'd0, 3'b010, 2'b01, 8'd0});
                  aw_hs_cyc = cyc;
                  if (aw_q.size() > 0) void'(aw_q.pop_front());
               end
            end
            if (m_axi_wvalid) begin
               if (w_q.size() == 0) check("w_unexpected", 1, 0);
               else check("wdata_wstrb_wlast", {m_axi_wdata, m_axi_wstrb, m_axi_wlast},
                          {w_q[0], 1'b1});
               if (m_axi_wready) begin
                  w_hs_cyc = cyc;
                  if (w_q.size() > 0) void'(w_q.pop_front());
               end
            end
            if (m_axi_arvalid) begin
               ar_vcnt++;
               if (ar_q.size() == 0) check("ar_unexpected", 1, 0);
               else check("araddr", m_axi_araddr, ar_q[0]);
               if (m_axi_arready) begin
                  ar_hs_cyc = cyc; ar_cycles_last = ar_vcnt; ar_vcnt = 0;
                  if (ar_q.size() > 0) void'(ar_q.pop_front());
               end
            end
            if (m_axi_bready && !bready_prev) bready_cyc = cyc;
            bready_prev = m_axi_bready;
            if (data_gnt_o)
               check("gnt_while_busy", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                                        m_axi_bready, m_axi_rready, data_rvalid_o}, 0);
            if (data_rvalid_o) begin
               rv_count++; rv_cyc = cyc;
               if (rsp_q.size() == 0) check("rvalid_unexpected", 1, 0);
               else begin
                  rsp_t e;
                  e = rsp_q.pop_front();
                  check("data_rdata", data_rdata_o, e.rdata);
                  check("data_err", data_err_o, e.err);
               end
            end
         end
      end
   end

   task automatic push_expect(input logic we, input logic [31:0] exp_ax, input logic [3:0] be,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic [1:0] resp);
      rsp_t e;
      if (we) begin
         aw_q.push_back(exp_ax);
         w_q.push_back({wdata, be});
         slv_b_q.push_back(resp);
         e.rdata = model_rdata;
      end else begin
         ar_q.push_back(exp_ax);
         slv_r_q.push_back({rdata, resp});
         e.rdata = rdata;
         model_rdata = rdata;
      end
      e.err = (resp != 2'b00);
      rsp_q.push_back(e);
   endtask

   task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] exp_ax,
                         input logic [3:0] be, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic [1:0] resp,
                         output int t_gnt, output int t_rv);
      int n, rv0;
      push_expect(we, exp_ax, be, wdata, rdata, resp);
      @(negedge clk_i);
      data_req_i = 1; data_we_i = we; data_addr_i = addr; data_be_i = be; data_wdata_i = wdata;
      #1; n = 0;
      while (!data_gnt_o && n < 50) begin @(negedge clk_i); #1; n++; end
      check("gnt_seen", data_gnt_o, 1);
      t_gnt = cyc; rv0 = rv_count;
      @(negedge clk_i);
      data_req_i = 0;
      n = 0;
      while (rv_count == rv0 && n < 100) begin @(negedge clk_i); #3; n++; end
      check("rvalid_seen", rv_count != rv0, 1);
      t_rv = rv_cyc;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t_gnt, t_rv, rv_before, n, n_gnt, prev;
      logic [31:0] b2b_addr [3];
      logic [31:0] b2b_data [3];
      b2b_addr = '{32'h5000_0000, 32'h5000_0104, 32'h5000_0208};
      b2b_data = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};

      // Reset values, with a request already pending
      data_req_i = 1;
      repeat (3) @(negedge clk_i);
      #1;
      check("rst_gnt", data_gnt_o, 0);
      check("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
                           m_axi_rready, data_rvalid_o, data_err_o}, 0);
      check("rst_rdata", data_rdata_o, 0);
      check("rst_regs", {m_axi_awaddr, m_axi_wstrb}, 0);
      check("rst_wdata", m_axi_wdata, 0);
      data_req_i = 0;
      @(negedge clk_i); #1 reset_ni = 1;

      // Unaligned write, zero-wait slave
      do_txn(1, 32'h1000_0006, 32'h1000_0004, 4'hC, 32'hDEAD_BEEF, 0, 2'b00, t_gnt, t_rv);
      check("wr_latency", t_rv - t_gnt, 3);

      // Read with 5 wait cycles on arready
      ar_wait = 5;
      do_txn(0, 32'h2000_0000, 32'h2000_0000, 4'hF, 0, 32'h1234_5678, 2'b00, t_gnt, t_rv);
      check("ar_valid_cycles", ar_cycles_last, 6);
      check("rd_after_ar", t_rv - ar_hs_cyc, 2);
      ar_wait = 0;

      // W three cycles before AW
      aw_wait = 3; w_wait = 0; rv_before = rv_count;
      do_txn(1, 32'h3000_0010, 32'h3000_0010, 4'hF, 32'hA5A5_A5A5, 0, 2'b00, t_gnt, t_rv);
      check("w_before_aw", aw_hs_cyc - w_hs_cyc, 3);
      check("bready_after_both_1", bready_cyc, t_gnt + 5);
      check("wr_latency_aw_late", t_rv - t_gnt, 6);
      repeat (4) @(negedge clk_i);
      check("one_rvalid_1", rv_count - rv_before, 1);

      // AW three cycles before W
      aw_wait = 0; w_wait = 3; rv_before = rv_count;
      do_txn(1, 32'h3000_0023, 32'h3000_0020, 4'h3, 32'h0F0F_1234, 0, 2'b00, t_gnt, t_rv);
      check("aw_before_w", w_hs_cyc - aw_hs_cyc, 3);
      check("bready_after_both_2", bready_cyc, t_gnt + 5);
      repeat (4) @(negedge clk_i);
      check("one_rvalid_2", rv_count - rv_before, 1);
      w_wait = 0;

      // Error responses
      do_txn(0, 32'h6000_0004, 32'h6000_0004, 4'hF, 0, 32'hCAFE_F00D, 2'b10, t_gnt, t_rv);
      do_txn(1, 32'h6000_0008, 32'h6000_0008, 4'h1, 32'h0000_00AA, 0, 2'b11, t_gnt, t_rv);

      // Three back-to-back reads with the request held high
      rv_before = rv_count; n_gnt = 0; prev = 0; n = 0;
      push_expect(0, b2b_addr[0], 4'hF, 0, b2b_data[0], 2'b00);
      @(negedge clk_i);
      data_req_i = 1; data_we_i = 0; data_addr_i = b2b_addr[0]; data_be_i = 4'hF;
      while (n_gnt < 3 && n < 60) begin
         #1;
         if (data_gnt_o) begin
            if (n_gnt > 0) check("gnt_spacing", cyc - prev, 4);
            prev = cyc; n_gnt++;
            @(negedge clk_i);
            if (n_gnt < 3) begin
               push_expect(0, b2b_addr[n_gnt], 4'hF, 0, b2b_data[n_gnt], 2'b00);
               data_addr_i = b2b_addr[n_gnt];
            end else data_req_i = 0;
         end else @(negedge clk_i);
         n++;
      end
      check("b2b_grants", n_gnt, 3);
      n = 0;
      while (rv_count < rv_before + 3 && n < 20) begin @(negedge clk_i); #3; n++; end
      check("b2b_rvalids", rv_count - rv_before, 3);

      // Reset while AW is stalled in WR_REQ
      aw_wait = 20;
      push_expect(1, 32'h7000_0000, 4'hF, 32'h5555_AAAA, 0, 2'b00);
      @(negedge clk_i);
      data_req_i = 1; data_we_i = 1; data_addr_i = 32'h7000_0000; data_wdata_i = 32'h5555_AAAA;
      #1 check("rst_test_gnt", data_gnt_o, 1);
      @(negedge clk_i); data_req_i = 0;
      @(negedge clk_i); #1;
      check("awvalid_before_rst", m_axi_awvalid, 1);
      #2 reset_ni = 0;
      #1;
      check("valids_drop_on_rst", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
                                   m_axi_rready, data_rvalid_o}, 0);
      aw_q.delete(); w_q.delete(); rsp_q.delete(); slv_b_q.delete();
      model_rdata = '0; aw_wait = 0;
      @(negedge clk_i); @(negedge clk_i); #1 reset_ni = 1;
      do_txn(0, 32'h4000_0008, 32'h4000_0008, 4'hF, 0, 32'h0BAD_F00D, 2'b00, t_gnt, t_rv);
      check("rd_after_rst_latency", t_rv - t_gnt, 3);

      repeat (5) @(negedge clk_i);
      check("scoreboard_drained", rsp_q.size() + aw_q.size() + w_q.size() + ar_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
